// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one MiniUART transmitter among NREQ byte producers.
// Define UART_ARB_BAUDCFG_EN to write the RX/TX baud divisors once after every reset.

`ifndef OFF_UART_DATA
`define OFF_UART_DATA 3'h0
`endif
`ifndef OFF_UART_LSR
`define OFF_UART_LSR 3'h1
`endif
`ifndef OFF_UART_DIVR
`define OFF_UART_DIVR 3'h2
`endif
`ifndef OFF_UART_DIVT
`define OFF_UART_DIVT 3'h3
`endif
`ifndef BAUD_RCV_9600
`define BAUD_RCV_9600 16'd162
`endif
`ifndef BAUD_SND_9600
`define BAUD_SND_9600 16'd2604
`endif

module uart_tx_arbiter #(
  parameter int unsigned NREQ     = 2,
  parameter int unsigned HOLD_CYC = 4,
  parameter logic [15:0] DIVR_VAL = `BAUD_RCV_9600,
  parameter logic [15:0] DIVT_VAL = `BAUD_SND_9600
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  input  logic [NREQ-1:0]     req,
  input  logic [8*NREQ-1:0]   req_data,
  output logic [NREQ-1:0]     gnt,
  output logic                busy,
  output logic [2:0]          uart_add,
  output logic [31:0]         uart_dat_o,
  input  logic [31:0]         uart_dat_i,
  output logic                uart_stb,
  output logic                uart_we
);

  localparam int unsigned     IDX_W     = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam logic [2:0]      ADD_DATA  = `OFF_UART_DATA;
  localparam logic [2:0]      ADD_LSR   = `OFF_UART_LSR;
  localparam logic [2:0]      ADD_DIVR  = `OFF_UART_DIVR;
  localparam logic [2:0]      ADD_DIVT  = `OFF_UART_DIVT;
  localparam logic [7:0]      HOLD_LOAD = 8'(HOLD_CYC - 1);
  localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(NREQ - 1);

  typedef enum logic [2:0] {
    RST_W,
    CFG_R,
    CFG_T,
    IDLE,
    POLL,
    WRITE,
    HOLD
  } state_e;

  state_e           state_q, state_d;
  logic [IDX_W-1:0] win_q, win_d;
  logic [IDX_W-1:0] last_q, last_d;
  logic [7:0]       cnt_q, cnt_d;
  logic [NREQ-1:0]  gnt_q, gnt_d;
  logic             busy_q, busy_d;
  logic [2:0]       add_q, add_d;
  logic [31:0]      dat_q, dat_d;
  logic             stb_q, stb_d;
  logic             we_q, we_d;

  logic             ts;
  logic [7:0]       win_byte;
  logic             unused_dat;

  // Only the transmitter-idle flag of the line status register matters here.
  assign ts         = uart_dat_i[5];
  assign unused_dat = ^{uart_dat_i[31:6], uart_dat_i[4:0]};

  // Scan from the farthest slot back to the nearest so the nearest requester after last wins.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NREQ-1:0] r,
                                               input logic [IDX_W-1:0] last);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    pick = last;
    for (int unsigned k = NREQ; k >= 1; k--) begin
      idx = IDX_W'((32'(last) + k) % NREQ);
      if (r[idx]) pick = idx;
    end
    return pick;
  endfunction

  always_comb begin
    state_d = state_q;
    win_d   = win_q;
    last_d  = last_q;
    cnt_d   = cnt_q;

    unique case (state_q)
      RST_W: begin
`ifdef UART_ARB_BAUDCFG_EN
        state_d = CFG_R;
`else
        state_d = IDLE;
`endif
      end
      CFG_R: state_d = CFG_T;
      CFG_T: state_d = IDLE;
      IDLE: begin
        if (|req) begin
          win_d   = rr_pick(req, last_q);
          state_d = POLL;
        end
      end
      POLL: begin
        if (!req[win_q]) begin
          state_d = IDLE;
        end else if (ts) begin
          state_d = WRITE;
        end
      end
      WRITE: begin
        last_d  = win_q;
        cnt_d   = HOLD_LOAD;
        state_d = HOLD;
      end
      HOLD: begin
        if (cnt_q == 8'd0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - 8'd1;
        end
      end
      default: state_d = RST_W;
    endcase
  end

  assign win_byte = req_data[{win_d, 3'b000} +: 8];

  // Outputs are decoded from the next state so they register in step with it.
  always_comb begin
    gnt_d  = '0;
    busy_d = (state_d != IDLE) && (state_d != RST_W);
    add_d  = 3'd0;
    dat_d  = 32'd0;
    stb_d  = 1'b0;
    we_d   = 1'b0;

    unique case (state_d)
      CFG_R: begin
        stb_d = 1'b1;
        we_d  = 1'b1;
        add_d = ADD_DIVR;
        dat_d = {16'd0, DIVR_VAL};
      end
      CFG_T: begin
        stb_d = 1'b1;
        we_d  = 1'b1;
        add_d = ADD_DIVT;
        dat_d = {16'd0, DIVT_VAL};
      end
      POLL: begin
        stb_d = 1'b1;
        add_d = ADD_LSR;
      end
      WRITE: begin
        stb_d        = 1'b1;
        we_d         = 1'b1;
        add_d        = ADD_DATA;
        dat_d        = {24'd0, win_byte};
        gnt_d[win_d] = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge CLK_I or negedge RST_I) begin
    if (!RST_I) begin
      state_q <= RST_W;
      win_q   <= '0;
      last_q  <= LAST_RST;
      cnt_q   <= 8'd0;
      gnt_q   <= '0;
      busy_q  <= 1'b0;
      add_q   <= 3'd0;
      dat_q   <= 32'd0;
      stb_q   <= 1'b0;
      we_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q   <= win_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      gnt_q   <= gnt_d;
      busy_q  <= busy_d;
      add_q   <= add_d;
      dat_q   <= dat_d;
      stb_q   <= stb_d;
      we_q    <= we_d;
    end
  end

  assign gnt        = gnt_q;
  assign busy       = busy_q;
  assign uart_add   = add_q;
  assign uart_dat_o = dat_q;
  assign uart_stb   = stb_q;
  assign uart_we    = we_q;

endmodule

// File: doc/uart_tx_arbiter.md
# uart_tx_arbiter

Round-robin transmit arbiter that shares one MiniUART among NREQ byte producers (e.g. CPU console path, debug trace engine). It masters the UART's WISHBONE-style slave port, polls the line status register until the transmitter is idle, writes the granted byte to the data register, and enforces a hold-off before the next poll. Optionally programs the UART baud divisors once after reset.

## Interface
Parameters:
- NREQ, 2: number of requesters, 1..8.
- HOLD_CYC, 4: idle cycles after each data write before re-polling, 2..255.
- DIVR_VAL, `BAUD_RCV_9600 (head_uart.v): RX divisor written at start-up (UART_ARB_BAUDCFG_EN only).
- DIVT_VAL, `BAUD_SND_9600 (head_uart.v): TX divisor written at start-up (UART_ARB_BAUDCFG_EN only).

Ports:
- CLK_I  in  1  clock, shared with the MiniUART.
- RST_I  in  1  reset, asynchronous, active-low.
- req  in  NREQ  per-requester byte-pending flag.
- req_data  in  8*NREQ  byte of requester i on [8i+7:8i]; stable while req[i]=1.
- gnt  out  NREQ  one-cycle pulse: byte of requester i written to UART this cycle.
- busy  out  1  arbiter not in IDLE.
- uart_add  out  3  UART ADD_I[4:2].
- uart_dat_o  out  32  UART DAT_I.
- uart_dat_i  in  32  UART DAT_O (combinational read data).
- uart_stb  out  1  UART STB_I.
- uart_we  out  1  UART WE_I.

## Operation
- States: RST_W, CFG_R, CFG_T, IDLE, POLL, WRITE, HOLD. Reset state RST_W.
- All outputs are Moore-decoded from state/winner; reset values: gnt=0, busy=0, uart_stb=0, uart_we=0, uart_add=0, uart_dat_o=0.
- RST_W: outputs idle; next state CFG_R (macro on) or IDLE (macro off). Guarantees one cycle for the UART's synchronous reset to clear.
- CFG_R: stb=1, we=1, add=`OFF_UART_DIVR, dat_o={16'b0,DIVR_VAL} -> CFG_T. CFG_T: same with `OFF_UART_DIVT, DIVT_VAL -> IDLE.
- IDLE: if |req, select winner by round robin starting at (last+1) mod NREQ, latch winner -> POLL; else stay. last resets to NREQ-1 (req[0] first).
- POLL: stb=1, we=0, add=`OFF_UART_LSR. uart_dat_i[5] (ts) =1 -> WRITE; =0 -> stay. If req[winner] dropped -> IDLE, no write, last unchanged.
- WRITE: stb=1, we=1, add=`OFF_UART_DATA, dat_o={24'b0, req_data[winner]}; gnt[winner]=1; last<=winner; cnt<=HOLD_CYC-1 -> HOLD.
- HOLD: stb=0; cnt decrements; at cnt=0 -> IDLE. Covers UART load toggle and ts fall.
- busy = (state != IDLE) and not RST_W.
- Requesters must hold req and data until gnt; requester drops req in the gnt cycle or re-asserts for another byte.
- New req arriving while busy waits; fairness: a requester waits at most NREQ-1 other grants.

## Timing
- Zero-wait UART: req[i] rising in IDLE at cycle n -> POLL n+1 -> WRITE/gnt[i] n+2 -> HOLD n+3..n+2+HOLD_CYC -> IDLE n+3+HOLD_CYC.
- Minimum byte spacing: HOLD_CYC+3 cycles plus TX serialisation time (bounded by ts polling).
- Async reset mid-transaction: state forced to RST_W immediately, stb/we drop in the same cycle; no gnt issued; pending byte is re-arbitrated after reset.
- cnt is 8 bits; HOLD_CYC outside 2..255 is illegal.

## Configuration
- UART_ARB_BAUDCFG_EN defined: CFG_R/CFG_T run once after each reset, two write cycles, then IDLE; first grant no earlier than cycle 4 after reset release.
- Undefined: CFG states unreachable; UART keeps its reset divisors; IDLE reached one cycle after reset release.

## Test plan
- Single requester, NREQ=2, req[0]=1, data 8'h41, ts=1 -> POLL then WRITE with add=DATA, dat_o=32'h41, gnt=2'b01 exactly once, busy low HOLD_CYC+1 cycles later.
- Both req, data0=8'hA5, data1=8'h5A held -> gnts alternate 01,10,01,10; dat_o sequence A5,5A,A5,5A.
- ts held 0 for 50 cycles -> stays in POLL (stb=1, we=0) 50 cycles, no gnt; ts=1 -> WRITE next cycle.
- req[1] dropped while in POLL -> returns IDLE, no write strobe, gnt stays 0.
- RST_I pulsed low during HOLD and during WRITE -> stb/we/gnt 0 asynchronously; after release, next grant goes to req[0].
- With UART_ARB_BAUDCFG_EN, DIVR_VAL=16'd27, DIVT_VAL=16'd27 -> after reset, writes to DIVR then DIVT with dat_o=32'd27 before any POLL.
